// File: rtl/rv_multicycle_ctrl_if.sv
// Handshake and control bus between the multi-cycle controller and its datapath/bench.
interface rv_multicycle_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 3
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic                  zero_flag;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] reg1_addr;
    logic [REG_ADDR_W-1:0] reg2_addr;
    logic [REG_ADDR_W-1:0] write_reg_addr;
    logic [XLEN-1:0]       imm;
    logic [ALUOP_W-1:0]    alu_op;
    logic                  alu_src_imm;
    logic                  reg_we;
    logic                  mem_re;
    logic                  mem_we;
    logic                  mem_to_reg;
    logic                  branch_taken;
    logic                  done;
    logic                  illegal;
    logic                  mem_err;

    // Controller side
    modport slave (
        input  instr_valid, instr, zero_flag, mem_ready,
        output instr_ready, reg1_addr, reg2_addr, write_reg_addr, imm, alu_op,
               alu_src_imm, reg_we, mem_re, mem_we, mem_to_reg, branch_taken,
               done, illegal, mem_err
    );

    // Instruction source / datapath side
    modport master (
        output instr_valid, instr, zero_flag, mem_ready,
        input  instr_ready, reg1_addr, reg2_addr, write_reg_addr, imm, alu_op,
               alu_src_imm, reg_we, mem_re, mem_we, mem_to_reg, branch_taken,
               done, illegal, mem_err
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32 control unit: accepts one instruction, decodes fields/immediate,
// then walks DECODE/EXEC/MEM/WB emitting register-file, ALU and memory strobes.
module rv_multicycle_ctrl #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_RTYPE    = 1'b1
) (
    input logic                clk,
    input logic                reset,
    rv_multicycle_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(7);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_ILL} cls_t;

    // ---------------- instruction decode (valid while instr is presented) -------
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               f7b5;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b;
    logic [ALUOP_W-1:0] f3_op;
    logic               f3_bad;
    cls_t               dec_cls;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_src_imm;
    logic [XLEN-1:0]    dec_imm;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign f7b5   = bus.instr[30];
    assign imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b  = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};

    // funct3 -> ALU operation, shared by OP and OP-IMM; arithmetic right shift unsupported
    always_comb begin
        f3_op  = ALU_ADD;
        f3_bad = 1'b0;
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  begin f3_op = ALU_SRL; f3_bad = f7b5; end
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_bad = 1'b1;
        endcase
    end

    // Opcode class, ALU operation, operand-B select and immediate format
    always_comb begin
        dec_cls     = C_ILL;
        dec_alu_op  = f3_op;
        dec_src_imm = 1'b0;
        dec_imm     = imm_i;
        case (opcode)
            7'b0010011: begin
                dec_cls     = f3_bad ? C_ILL : C_ALU;
                dec_src_imm = 1'b1;
            end
            7'b0110011: begin
                dec_cls = (EN_RTYPE && !f3_bad) ? C_ALU : C_ILL;
                if (funct3 == 3'b000 && f7b5) dec_alu_op = ALU_SUB;
            end
            7'b0000011: begin
                dec_cls     = (funct3 == 3'b010) ? C_LW : C_ILL;
                dec_alu_op  = ALU_ADD;
                dec_src_imm = 1'b1;
            end
            7'b0100011: begin
                dec_cls     = (funct3 == 3'b010) ? C_SW : C_ILL;
                dec_alu_op  = ALU_ADD;
                dec_src_imm = 1'b1;
                dec_imm     = imm_s;
            end
            7'b1100011: begin
                dec_cls    = (funct3 == 3'b000) ? C_BEQ : C_ILL;
                dec_alu_op = ALU_SUB;
                dec_imm    = imm_b;
            end
            default: ;
        endcase
    end

    // ---------------- sequencer state ----------------
    state_t                state_q, state_d;
    cls_t                  cls_q, cls_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]       imm_q, imm_d;
    logic [ALUOP_W-1:0]    alu_op_q, alu_op_d;
    logic                  src_imm_q, src_imm_d;
    logic                  ready_q, ready_d;
    logic                  reg_we_q, reg_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic                  m2r_q, m2r_d;
    logic                  done_q, done_d;
    logic                  ill_q, ill_d;
    logic                  err_q, err_d;
    logic                  beq_exec_q, beq_exec_d;

    // Next state and next registered outputs; pulses default low every cycle
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cnt_d      = cnt_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        alu_op_d   = alu_op_q;
        src_imm_d  = src_imm_q;
        reg_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        m2r_d      = 1'b0;
        done_d     = 1'b0;
        ill_d      = 1'b0;
        err_d      = 1'b0;
        beq_exec_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    state_d   = S_DECODE;
                    cls_d     = dec_cls;
                    rs1_d     = REG_ADDR_W'(bus.instr[19:15]);
                    rs2_d     = REG_ADDR_W'(bus.instr[24:20]);
                    rd_d      = REG_ADDR_W'(bus.instr[11:7]);
                    imm_d     = dec_imm;
                    alu_op_d  = dec_alu_op;
                    src_imm_d = dec_src_imm;
                    ill_d     = (dec_cls == C_ILL);
                end
            end
            S_DECODE: begin
                if (cls_q == C_ILL) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                    if (cls_q == C_BEQ) begin
                        done_d     = 1'b1;
                        beq_exec_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LW:    begin state_d = S_MEM; mem_re_d = 1'b1; end
                    C_SW:    begin state_d = S_MEM; mem_we_d = 1'b1; end
                    C_BEQ:   state_d = S_IDLE;
                    default: begin
                        state_d  = S_WB;
                        reg_we_d = (rd_q != '0);
                        done_d   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    cnt_d = '0;
                    if (cls_q == C_LW) begin
                        state_d  = S_WB;
                        reg_we_d = (rd_q != '0);
                        m2r_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q + CNT_W'(1) == CNT_W'(MEM_TIMEOUT)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    mem_re_d = mem_re_q;
                    mem_we_d = mem_we_q;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; async reset drops any in-flight instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cls_q      <= C_ILL;
            cnt_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_op_q   <= '0;
            src_imm_q  <= 1'b0;
            ready_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            m2r_q      <= 1'b0;
            done_q     <= 1'b0;
            ill_q      <= 1'b0;
            err_q      <= 1'b0;
            beq_exec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            cnt_q      <= cnt_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            alu_op_q   <= alu_op_d;
            src_imm_q  <= src_imm_d;
            ready_q    <= ready_d;
            reg_we_q   <= reg_we_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            m2r_q      <= m2r_d;
            done_q     <= done_d;
            ill_q      <= ill_d;
            err_q      <= err_d;
            beq_exec_q <= beq_exec_d;
        end
    end

    assign bus.instr_ready    = ready_q;
    assign bus.reg1_addr      = rs1_q;
    assign bus.reg2_addr      = rs2_q;
    assign bus.write_reg_addr = rd_q;
    assign bus.imm            = imm_q;
    assign bus.alu_op         = alu_op_q;
    assign bus.alu_src_imm    = src_imm_q;
    assign bus.reg_we         = reg_we_q;
    assign bus.mem_re         = mem_re_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_to_reg     = m2r_q;
    assign bus.illegal        = ill_q;
    assign bus.mem_err        = err_q;
    // zero_flag is only valid during EXEC and a store retires in its mem_ready cycle,
    // so these two terms are gated by registered state but follow the live input.
    assign bus.branch_taken   = beq_exec_q & bus.zero_flag;
    assign bus.done           = done_q | ((state_q == S_MEM) && (cls_q == C_SW) && bus.mem_ready);
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: per-instruction event timelines vs hand-computed values.
module tb_rv_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rv_multicycle_ctrl_if #(.XLEN(32), .REG_ADDR_W(5), .ALUOP_W(3)) bus  ();
    rv_multicycle_ctrl_if #(.XLEN(32), .REG_ADDR_W(5), .ALUOP_W(3)) bus2 ();

    rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .EN_RTYPE(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .EN_RTYPE(1'b0)) dut_nr (
        .clk(clk), .reset(reset), .bus(bus2));

    // second controller sees the same instruction stream
    assign bus2.instr_valid = bus.instr_valid;
    assign bus2.instr       = bus.instr;
    assign bus2.zero_flag   = bus.zero_flag;
    assign bus2.mem_ready   = bus.mem_ready;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-run timeline (cycle 1 = DECODE, first cycle after accept; -1 = never seen)
    int done_at, done_n, rwe_at, rwe_n, m2r_at, re_n, we_n, br_at, br_n;
    int ill_at, ill_n, ill2_at, err_at, rdy_at;
    logic [31:0] imm1, imm_end;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  aop;
    logic        asrc, rdy1;

    function automatic logic [9:0] ctl();
        return {bus.instr_ready, bus.reg_we, bus.mem_re, bus.mem_we, bus.mem_to_reg,
                bus.branch_taken, bus.done, bus.illegal, bus.mem_err, bus.alu_src_imm};
    endfunction

    task automatic accept(input logic [31:0] ins, input logic zf);
        for (int i = 0; i < 50 && !bus.instr_ready; i++) begin
            @(posedge clk); #1;
        end
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.zero_flag   = zf;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF; // fields must come from the latched copy
    endtask

    // wait_c: MEM cycle (1-based) in which memory answers; 0 = never
    task automatic run(input logic [31:0] ins, input int wait_c, input logic zf);
        int scnt = 0;
        done_at = -1; rwe_at = -1; m2r_at = -1; br_at = -1; ill_at = -1; ill2_at = -1;
        err_at = -1; rdy_at = -1;
        done_n = 0; rwe_n = 0; re_n = 0; we_n = 0; br_n = 0; ill_n = 0;
        accept(ins, zf);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (bus.mem_re || bus.mem_we) scnt++;
            bus.mem_ready = (wait_c > 0) && (bus.mem_re || bus.mem_we) && (scnt == wait_c);
            #1;
            if (c == 1) begin
                imm1 = bus.imm; rs1 = bus.reg1_addr; rs2 = bus.reg2_addr;
                rd = bus.write_reg_addr; aop = bus.alu_op; asrc = bus.alu_src_imm;
                rdy1 = bus.instr_ready;
            end
            if (bus.done)         begin done_n++; if (done_at < 0) done_at = c; end
            if (bus.reg_we)       begin rwe_n++;  if (rwe_at < 0)  rwe_at = c;  end
            if (bus.mem_to_reg && m2r_at < 0) m2r_at = c;
            if (bus.branch_taken) begin br_n++;   if (br_at < 0)   br_at = c;   end
            if (bus.illegal)      begin ill_n++;  if (ill_at < 0)  ill_at = c;  end
            if (bus2.illegal && ill2_at < 0) ill2_at = c;
            if (bus.mem_err && err_at < 0) err_at = c;
            if (bus.mem_re) re_n++;
            if (bus.mem_we) we_n++;
            if (bus.instr_ready) begin rdy_at = c; break; end
            imm_end = bus.imm;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic chk_run(input string tag, input int e_done, input int e_rwe, input int e_rdy);
        chk({tag, "_done_at"}, done_at, e_done);
        chk({tag, "_done_n"}, done_n, (e_done < 0) ? 0 : 1);
        chk({tag, "_rwe_at"}, rwe_at, e_rwe);
        chk({tag, "_ready_at"}, rdy_at, e_rdy);
        chk({tag, "_busy_ready"}, rdy1, (e_rdy == 1) ? 1 : 0);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.zero_flag   = 1'b0;
        bus.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", ctl(), 10'h0);
        chk("reset_imm", bus.imm, 32'h0);
        chk("reset_aop", bus.alu_op, 3'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", bus.instr_ready, 1'b1);

        // addi x18,x0,8
        run(32'h0080_0913, 0, 1'b0);
        chk_run("addi", 3, 3, 4);
        chk("addi_rd", rd, 5'd18);
        chk("addi_rs1", rs1, 5'd0);
        chk("addi_imm", imm1, 32'd8);
        chk("addi_imm_hold", imm_end, 32'd8);
        chk("addi_aop", aop, 3'b000);
        chk("addi_src", asrc, 1'b1);
        chk("addi_rwe_n", rwe_n, 1);

        // sw x18,4(x0), memory answers in 2nd MEM cycle
        run(32'h0120_2223, 2, 1'b0);
        chk_run("sw", 4, -1, 5);
        chk("sw_we_n", we_n, 2);
        chk("sw_re_n", re_n, 0);
        chk("sw_imm", imm1, 32'd4);
        chk("sw_rs2", rs2, 5'd18);
        chk("sw_src", asrc, 1'b1);
        chk("sw_aop", aop, 3'b000);

        // beq x1,x1,8 taken and not taken
        run(32'h0010_8463, 0, 1'b1);
        chk_run("beq_t", 2, -1, 3);
        chk("beq_t_br_at", br_at, 2);
        chk("beq_t_br_n", br_n, 1);
        chk("beq_aop", aop, 3'b001);
        chk("beq_imm", imm1, 32'd8);
        chk("beq_src", asrc, 1'b0);
        chk("beq_rs", {rs1, rs2}, {5'd1, 5'd1});
        run(32'h0010_8463, 0, 1'b0);
        chk_run("beq_nt", 2, -1, 3);
        chk("beq_nt_br_n", br_n, 0);

        // lw x5,0(x1), memory never answers -> timeout after 16 MEM cycles
        run(32'h0000_A283, 0, 1'b0);
        chk_run("lw_to", -1, -1, 19);
        chk("lw_to_re_n", re_n, 16);
        chk("lw_to_err_at", err_at, 19);

        // lw x6,-4(x2), memory answers in first MEM cycle
        run(32'hFFC1_2303, 1, 1'b0);
        chk_run("lw", 4, 4, 5);
        chk("lw_re_n", re_n, 1);
        chk("lw_m2r_at", m2r_at, 4);
        chk("lw_imm", imm1, 32'hFFFF_FFFC);
        chk("lw_rd", rd, 5'd6);
        chk("lw_err_at", err_at, -1);

        // illegal opcode
        run(32'h0000_007F, 0, 1'b0);
        chk_run("ill_op", -1, -1, 2);
        chk("ill_op_at", ill_at, 1);
        chk("ill_op_n", ill_n, 1);

        // sub x3,x1,x2: legal with R-type enabled, illegal on the R-type-disabled instance
        run(32'h4020_81B3, 0, 1'b0);
        chk_run("sub", 3, 3, 4);
        chk("sub_aop", aop, 3'b001);
        chk("sub_src", asrc, 1'b0);
        chk("sub_ill_n", ill_n, 0);
        chk("nort_ill_at", ill2_at, 1);

        // OP-IMM funct3=011 and load funct3=100 are illegal
        run(32'h0020_B193, 0, 1'b0);
        chk("ill_f3_at", ill_at, 1);
        chk("ill_f3_done_n", done_n, 0);
        run(32'h0000_C283, 0, 1'b0);
        chk("ill_lw_f3_at", ill_at, 1);
        chk("ill_lw_f3_re_n", re_n, 0);

        // xori x7,x1,-1
        run(32'hFFF0_C393, 0, 1'b0);
        chk_run("xori", 3, 3, 4);
        chk("xori_aop", aop, 3'b100);
        chk("xori_imm", imm1, 32'hFFFF_FFFF);

        // addi x0,x0,0: retires but never writes x0
        run(32'h0000_0013, 0, 1'b0);
        chk_run("nop", 3, -1, 4);

        // reset in the middle of a store's MEM phase
        accept(32'h0120_2223, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_we", bus.mem_we, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_mid_ctl", ctl(), 10'h0);
        @(posedge clk); #1;
        chk("rst_hold_ctl", ctl(), 10'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_ready", bus.instr_ready, 1'b1);
        run(32'h0080_0913, 0, 1'b0);
        chk_run("addi_after_rst", 3, 3, 4);
        chk("addi_after_rst_rd", rd, 5'd18);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
